seq_control_path: RTL and testbench

- Parametrised control FSM for the display/counter datapath; the next generation of the fixed-sequence control path.
- Drives the s register (step counter) and the y register (value/selector) through registered strobes.
- Four regimes: OFF, LIST (timed countdown sequence), COUNT (rate-divided up/down count with y carry), and LOAD (store x into y, then preset s).
- Sequence start value, step, length, dwell time and count rate are parameters rather than hard-coded states.

---
 rtl/seq_control_path.sv | 220 ++++++++++++++++++++++
 tb/tb_seq_control_path.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_control_path.sv
// seq_control_path: parametrised control FSM for the display/counter datapath.
// Issues registered strobes to the s (step counter) and y (value/selector)
// registers for four regimes: OFF, LIST (timed countdown), COUNT (rate-divided
// up/down count with y carry) and LOAD (store x into y, then preset s).
// Each state decides its outputs combinationally; they become visible on the
// edge that leaves the state, so every output is a plain register.
module seq_control_path #(
    parameter int S_W        = 4,
    parameter int LIST_START = 6,
    parameter int LIST_STEP  = 2,
    parameter int LIST_STEPS = 4,
    parameter int DWELL      = 3,
    parameter int COUNT_DIV  = 1,
    parameter int LOAD_VAL   = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     mode_req,
    input  logic           start,
    input  logic           dir,
    input  logic           y_carry,
    output logic [1:0]     regime,
    output logic           active,
    output logic           done,
    output logic           s_en,
    output logic           s_load,
    output logic [S_W-1:0] s_load_val,
    output logic           s_add,
    output logic [S_W-1:0] s_step,
    output logic           y_en,
    output logic           y_store_x,
    output logic [1:0]     y_select_next
);

    localparam int TMR_W = $clog2(DWELL + 1);
    localparam int CNT_W = $clog2(LIST_STEPS + 1);
    localparam int DIV_W = $clog2(COUNT_DIV + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LIST_WAIT,
        ST_LIST_RUN,
        ST_COUNT,
        ST_LOAD_X,
        ST_LOAD_SEL,
        ST_LOAD_S,
        ST_LOAD_END
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div, div_nxt;

    logic [1:0]     regime_nxt;
    logic           active_nxt, done_nxt;
    logic           s_en_nxt, s_load_nxt, s_add_nxt;
    logic [S_W-1:0] s_load_val_nxt, s_step_nxt;
    logic           y_en_nxt, y_store_x_nxt;
    logic [1:0]     y_select_next_nxt;

    // State, sequencing counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            tmr           <= '0;
            cnt           <= '0;
            div           <= '0;
            regime        <= 2'd0;
            active        <= 1'b0;
            done          <= 1'b0;
            s_en          <= 1'b0;
            s_load        <= 1'b0;
            s_load_val    <= '0;
            s_add         <= 1'b0;
            s_step        <= '0;
            y_en          <= 1'b0;
            y_store_x     <= 1'b0;
            y_select_next <= 2'd0;
        end else begin
            state         <= state_nxt;
            tmr           <= tmr_nxt;
            cnt           <= cnt_nxt;
            div           <= div_nxt;
            regime        <= regime_nxt;
            active        <= active_nxt;
            done          <= done_nxt;
            s_en          <= s_en_nxt;
            s_load        <= s_load_nxt;
            s_load_val    <= s_load_val_nxt;
            s_add         <= s_add_nxt;
            s_step        <= s_step_nxt;
            y_en          <= y_en_nxt;
            y_store_x     <= y_store_x_nxt;
            y_select_next <= y_select_next_nxt;
        end
    end

    // Next-state and next-output decode; strobes default low, operands hold.
    always_comb begin
        state_nxt         = state;
        tmr_nxt           = tmr;
        cnt_nxt           = cnt;
        div_nxt           = div;
        active_nxt        = active;
        done_nxt          = 1'b0;
        s_en_nxt          = 1'b0;
        s_load_nxt        = 1'b0;
        s_load_val_nxt    = s_load_val;
        s_add_nxt         = s_add;
        s_step_nxt        = s_step;
        y_en_nxt          = 1'b0;
        y_store_x_nxt     = 1'b0;
        y_select_next_nxt = y_select_next;

        case (state)
            ST_IDLE: begin
                case (mode_req)
                    2'd1: state_nxt = ST_LIST_WAIT;
                    2'd2: begin
                        state_nxt = ST_COUNT;
                        div_nxt   = '0;
                    end
                    2'd3: state_nxt = ST_LOAD_X;
                    default: state_nxt = ST_IDLE;
                endcase
            end
            ST_LIST_WAIT: begin
                if (mode_req == 2'd0) begin
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    s_en_nxt       = 1'b1;
                    s_load_nxt     = 1'b1;
                    s_load_val_nxt = S_W'(LIST_START);
                    active_nxt     = 1'b1;
                    tmr_nxt        = TMR_W'(DWELL - 1);
                    cnt_nxt        = CNT_W'(LIST_STEPS - 1);
                    state_nxt      = ST_LIST_RUN;
                end
            end
            ST_LIST_RUN: begin
                if (!start) begin
                    // Abort wins over any strobe due this cycle.
                    s_en_nxt       = 1'b1;
                    s_load_nxt     = 1'b1;
                    s_load_val_nxt = S_W'(LIST_START);
                    active_nxt     = 1'b0;
                    state_nxt      = ST_IDLE;
                end else if (tmr == '0) begin
                    tmr_nxt = TMR_W'(DWELL - 1);
                    if (cnt != '0) begin
                        s_en_nxt   = 1'b1;
                        s_add_nxt  = 1'b0;
                        s_step_nxt = S_W'(LIST_STEP);
                        cnt_nxt    = cnt - CNT_W'(1);
                    end else begin
                        s_en_nxt       = 1'b1;
                        s_load_nxt     = 1'b1;
                        s_load_val_nxt = S_W'(LIST_START);
                        active_nxt     = 1'b0;
                        done_nxt       = 1'b1;
                        state_nxt      = ST_IDLE;
                    end
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            ST_COUNT: begin
                if (start) begin
                    if (div == '0) begin
                        s_en_nxt   = 1'b1;
                        s_step_nxt = S_W'(1);
                        s_add_nxt  = dir;
                        div_nxt    = DIV_W'(COUNT_DIV - 1);
                        if (y_carry) begin
                            y_en_nxt          = 1'b1;
                            y_store_x_nxt     = 1'b0;
                            y_select_next_nxt = 2'd1;
                        end
                    end else begin
                        div_nxt = div - DIV_W'(1);
                    end
                end else begin
                    div_nxt = '0;
                    if (mode_req == 2'd0) state_nxt = ST_IDLE;
                end
            end
            ST_LOAD_X: begin
                y_en_nxt      = 1'b1;
                y_store_x_nxt = 1'b1;
                state_nxt     = ST_LOAD_SEL;
            end
            ST_LOAD_SEL: begin
                y_en_nxt          = 1'b1;
                y_store_x_nxt     = 1'b0;
                y_select_next_nxt = 2'd2;
                state_nxt         = ST_LOAD_S;
            end
            ST_LOAD_S: begin
                s_en_nxt       = 1'b1;
                s_load_nxt     = 1'b1;
                s_load_val_nxt = S_W'(LOAD_VAL);
                state_nxt      = ST_LOAD_END;
            end
            ST_LOAD_END: begin
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        case (state_nxt)
            ST_LIST_WAIT, ST_LIST_RUN:                     regime_nxt = 2'd1;
            ST_COUNT:                                      regime_nxt = 2'd2;
            ST_LOAD_X, ST_LOAD_SEL, ST_LOAD_S, ST_LOAD_END: regime_nxt = 2'd3;
            default:                                       regime_nxt = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_seq_control_path.sv
// Testbench for seq_control_path: vector table, hand-written corner sequences
// and randomized stimulus against a cycle-level behavioural model.
module tb_seq_control_path;

    localparam int S_W        = 4;
    localparam int LIST_START = 6;
    localparam int LIST_STEP  = 2;
    localparam int LIST_STEPS = 4;
    localparam int DWELL      = 3;
    localparam int COUNT_DIV  = 2;
    localparam int LOAD_VAL   = 0;
    localparam int S_MOD      = 1 << S_W;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     mode_req;
    logic           start, dir, y_carry;
    logic [1:0]     regime;
    logic           active, done, s_en, s_load, s_add, y_en, y_store_x;
    logic [S_W-1:0] s_load_val, s_step;
    logic [1:0]     y_select_next;

    seq_control_path #(
        .S_W(S_W), .LIST_START(LIST_START), .LIST_STEP(LIST_STEP),
        .LIST_STEPS(LIST_STEPS), .DWELL(DWELL), .COUNT_DIV(COUNT_DIV),
        .LOAD_VAL(LOAD_VAL)
    ) dut (
        .clk(clk), .rst(rst), .mode_req(mode_req), .start(start), .dir(dir),
        .y_carry(y_carry), .regime(regime), .active(active), .done(done),
        .s_en(s_en), .s_load(s_load), .s_load_val(s_load_val), .s_add(s_add),
        .s_step(s_step), .y_en(y_en), .y_store_x(y_store_x),
        .y_select_next(y_select_next)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int s_track  = 0;

    // Behavioural model: flow 0 idle, 1 list armed, 11 list running, 2 count, 3 load
    int m_flow, m_el, m_run, m_ld;
    int e_regime, e_active, e_done, e_s_en, e_s_load, e_s_load_val;
    int e_s_add, e_s_step, e_y_en, e_y_store_x, e_ysel;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flow = 0; m_el = 0; m_run = 0; m_ld = 0;
        e_regime = 0; e_active = 0; e_done = 0; e_s_en = 0; e_s_load = 0;
        e_s_load_val = 0; e_s_add = 0; e_s_step = 0; e_y_en = 0;
        e_y_store_x = 0; e_ysel = 0;
    endtask

    task automatic list_restore(input int with_done);
        e_s_en = 1; e_s_load = 1; e_s_load_val = LIST_START;
        e_active = 0; e_done = with_done; m_flow = 0;
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_edge();
        int n;
        e_done = 0; e_s_en = 0; e_s_load = 0; e_y_en = 0; e_y_store_x = 0;
        case (m_flow)
            0: begin
                if (mode_req == 2'd1) m_flow = 1;
                else if (mode_req == 2'd2) begin m_flow = 2; m_run = 0; end
                else if (mode_req == 2'd3) begin m_flow = 3; m_ld = 0; end
            end
            1: begin
                if (mode_req == 2'd0) m_flow = 0;
                else if (start) begin
                    e_s_en = 1; e_s_load = 1; e_s_load_val = LIST_START;
                    e_active = 1; m_el = 0; m_flow = 11;
                end
            end
            11: begin
                if (!start) list_restore(0);
                else begin
                    m_el++;
                    if (m_el % DWELL == 0) begin
                        n = m_el / DWELL;
                        if (n < LIST_STEPS) begin
                            e_s_en = 1; e_s_add = 0; e_s_step = LIST_STEP;
                        end else list_restore(1);
                    end
                end
            end
            2: begin
                if (start) begin
                    if (m_run % COUNT_DIV == 0) begin
                        e_s_en = 1; e_s_step = 1; e_s_add = dir;
                        if (y_carry) begin e_y_en = 1; e_ysel = 1; end
                    end
                    m_run++;
                end else begin
                    m_run = 0;
                    if (mode_req == 2'd0) m_flow = 0;
                end
            end
            default: begin
                m_ld++;
                case (m_ld)
                    1: begin e_y_en = 1; e_y_store_x = 1; end
                    2: begin e_y_en = 1; e_ysel = 2; end
                    3: begin e_s_en = 1; e_s_load = 1; e_s_load_val = LOAD_VAL; end
                    default: begin e_done = 1; m_flow = 0; end
                endcase
            end
        endcase
        e_regime = (m_flow == 11) ? 1 : m_flow;
    endtask

    task automatic check_model();
        chk("mdl_regime", regime, e_regime);
        chk("mdl_active", active, e_active);
        chk("mdl_done", done, e_done);
        chk("mdl_s_en", s_en, e_s_en);
        chk("mdl_s_load", s_load, e_s_load);
        chk("mdl_s_load_val", s_load_val, e_s_load_val);
        chk("mdl_s_add", s_add, e_s_add);
        chk("mdl_s_step", s_step, e_s_step);
        chk("mdl_y_en", y_en, e_y_en);
        chk("mdl_y_store_x", y_store_x, e_y_store_x);
        chk("mdl_y_select_next", y_select_next, e_ysel);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_regime"}, regime, 0);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_s_en"}, s_en, 0);
        chk({tag, "_s_load"}, s_load, 0);
        chk({tag, "_s_load_val"}, s_load_val, 0);
        chk({tag, "_s_add"}, s_add, 0);
        chk({tag, "_s_step"}, s_step, 0);
        chk({tag, "_y_en"}, y_en, 0);
        chk({tag, "_y_store_x"}, y_store_x, 0);
        chk({tag, "_y_select_next"}, y_select_next, 0);
    endtask

    // One clock: model edge, DUT edge, compare, emulate the s register.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
        if (s_en) begin
            if (s_load) s_track = int'(s_load_val);
            else if (s_add) s_track = (s_track + int'(s_step)) % S_MOD;
            else s_track = (s_track - int'(s_step) + S_MOD) % S_MOD;
        end
    endtask

    task automatic rst_pulse(input string tag);
        #3;
        rst = 1'b1;
        #1;
        check_zero(tag);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0] mr;
        logic       st, dr, yc;
        logic [1:0] rg;
        logic       sen, sld, yen, ysx, dn, act;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int strobes, ycnt, quiet;

        tbl[0]  = '{2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2'd3, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{2'd0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{2'd0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{2'd0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{2'd2, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{2'd2, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{2'd2, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{2'd2, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{2'd2, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{2'd1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{2'd1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{2'd0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; mode_req = 2'd0; start = 1'b0; dir = 1'b0; y_carry = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 16; i++) begin
            mode_req = tbl[i].mr; start = tbl[i].st; dir = tbl[i].dr; y_carry = tbl[i].yc;
            step();
            chk($sformatf("tbl%0d_regime", i), regime, tbl[i].rg);
            chk($sformatf("tbl%0d_s_en", i), s_en, tbl[i].sen);
            chk($sformatf("tbl%0d_s_load", i), s_load, tbl[i].sld);
            chk($sformatf("tbl%0d_y_en", i), y_en, tbl[i].yen);
            chk($sformatf("tbl%0d_y_store_x", i), y_store_x, tbl[i].ysx);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
            chk($sformatf("tbl%0d_active", i), active, tbl[i].act);
        end
        y_carry = 1'b0; dir = 1'b0;

        // Full LIST sequence: load 6, subtract 2 three times, restore with done
        mode_req = 2'd1; start = 1'b0;
        step();
        start = 1'b1;
        step();
        chk("list_first_load", {s_en, s_load}, 2'b11);
        chk("list_first_val", s_load_val, LIST_START);
        chk("list_first_active", active, 1);
        strobes = 1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (s_en) strobes++;
            if (k % 3 == 0 && k < 12) begin
                chk("list_sub_ctl", {s_en, s_load, s_add}, 3'b100);
                chk("list_sub_step", s_step, 2);
                chk("list_s_value", s_track, 6 - 2 * (k / 3));
                chk("list_active_mid", active, 1);
            end
        end
        chk("list_restore_load", {s_en, s_load}, 2'b11);
        chk("list_restore_s", s_track, 6);
        chk("list_done", done, 1);
        chk("list_active_end", active, 0);
        chk("list_regime_end", regime, 0);
        chk("list_strobe_total", strobes, 5);
        mode_req = 2'd0;
        step();

        // LIST abort four cycles after the first strobe
        mode_req = 2'd1; start = 1'b1;
        step();
        step();
        for (int k = 1; k <= 4; k++) step();
        start = 1'b0;
        step();
        chk("abort_load", {s_en, s_load}, 2'b11);
        chk("abort_val", s_load_val, LIST_START);
        chk("abort_done", done, 0);
        chk("abort_active", active, 0);
        chk("abort_regime", regime, 0);
        mode_req = 2'd0;

        // Asynchronous reset in the middle of LIST, then a quiet idle period
        mode_req = 2'd1; start = 1'b1;
        for (int k = 0; k < 5; k++) step();
        rst_pulse("rst_mid_list");
        mode_req = 2'd0; start = 1'b0;
        quiet = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (s_en || y_en) quiet++;
        end
        chk("idle_no_strobes", quiet, 0);

        // COUNT up, divide by 2, carry on the third strobe
        mode_req = 2'd2; dir = 1'b1; start = 1'b0;
        step();
        start = 1'b1; strobes = 0; ycnt = 0;
        for (int c = 1; c <= 8; c++) begin
            y_carry = (c == 5);
            step();
            if (s_en) begin
                strobes++;
                chk("count_step", s_step, 1);
                chk("count_add", s_add, 1);
            end
            if (y_en) begin
                ycnt++;
                chk("count_y_on_third", strobes, 3);
                chk("count_y_sel", y_select_next, 1);
                chk("count_y_store", y_store_x, 0);
            end
        end
        y_carry = 1'b0;
        chk("count_strobes", strobes, 4);
        chk("count_y_pulses", ycnt, 1);
        start = 1'b0; mode_req = 2'd0;
        step();
        chk("count_exit_regime", regime, 0);

        // LOAD presets s to 0, then COUNT down wraps to 15
        mode_req = 2'd3;
        step();
        mode_req = 2'd0;
        for (int k = 0; k < 4; k++) step();
        chk("load_done", done, 1);
        chk("load_regime", regime, 0);
        chk("load_s", s_track, LOAD_VAL);
        mode_req = 2'd2; dir = 1'b0;
        step();
        start = 1'b1;
        step();
        chk("wrap_strobe", {s_en, s_add}, 2'b10);
        chk("wrap_s", s_track, S_MOD - 1);
        chk("wrap_regime", regime, 2);
        start = 1'b0; mode_req = 2'd0;
        step();

        // Randomized stimulus against the model
        for (int r = 0; r < 600; r++) begin
            mode_req = 2'($urandom_range(0, 3));
            start    = ($urandom_range(0, 5) != 0);
            dir      = 1'($urandom_range(0, 1));
            y_carry  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) rst_pulse("rst_random");
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
